riscv_fetch_queue: RTL and testbench
====================================

RISCV_FETCH_QUEUE -- requirements
Module: riscv_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC/address width (32 or 64).
REQ-002 SHALL have parameter DEPTH, default 4: prefetch queue entries; power of two, 2..16.
REQ-003 SHALL have parameter RESET_PC, default 32'h0: first fetch address after reset.
REQ-004 SHALL have port clk  in  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1: synchronous, active-low reset.
REQ-006 SHALL have port imem_req_o  out  1: fetch request valid.
REQ-007 SHALL have port imem_addr_o  out  XLEN: fetch address, word aligned.
REQ-008 SHALL have port imem_gnt_i  in  1: request accepted this cycle.
REQ-009 SHALL have port imem_rvalid_i  in  1: in-order response valid.
REQ-010 SHALL have port imem_rdata_i  in  32: response instruction word.
REQ-011 SHALL have port redirect_i  in  1: flush and restart fetch (branch/jump resolved in ID).
REQ-012 SHALL have port redirect_pc_i  in  XLEN: restart address.
REQ-013 SHALL have port out_valid_o  out  1: queue head valid.
REQ-014 SHALL have port out_ready_i  in  1: decode accepts head.
REQ-015 SHALL have port out_inst_o  out  32: head instruction.
REQ-016 SHALL have port out_pc_o  out  XLEN: head PC.
REQ-017 SHALL have port out_pred_taken_o  out  1: head was a predecoded JAL that redirected fetch.
REQ-018 SHALL have port count_o  out  $clog2(DEPTH+1): occupied entries.

Function
REQ-019 SHALL keep fetch PC fpc; imem_addr_o = fpc; fpc advances by 4 on each imem_req_o && imem_gnt_i.
REQ-020 SHALL assert imem_req_o only when rst high, redirect_i low, and count + outstanding < DEPTH (credit rule; the queue cannot overflow).
REQ-021 SHALL hold imem_req_o and imem_addr_o stable until gnt, except when withdrawn by redirect_i.
REQ-022 SHALL track outstanding = granted minus returned responses, range 0..DEPTH.
REQ-023 SHALL tag each kept response with resp_pc (advances 4 per kept response) and enqueue {rdata, resp_pc} the cycle after imem_rvalid_i.
REQ-024 SHALL drive out_valid_o = (count != 0); dequeue on out_valid_o && out_ready_i; out_inst_o/out_pc_o stable while valid and not ready.
REQ-025 SHALL support enqueue and dequeue in the same cycle with count unchanged, including at count == DEPTH-1 and count == 1.
REQ-026 On redirect_i: SHALL empty queue next cycle, set fpc and resp_pc to {redirect_pc_i[XLEN-1:2], 2'b00}, set drop_cnt to outstanding minus imem_rvalid_i, suppress out_valid_o the same cycle.
REQ-027 SHALL discard responses while drop_cnt != 0, decrementing per response; no enqueue.
REQ-028 Zero-wait memory (gnt same cycle, rvalid next cycle): redirect at cycle 0 -> req at 1 -> rvalid at 2 -> out_valid_o at 3.
REQ-029 Back-to-back redirects SHALL each restart cleanly; latest redirect_pc_i wins.
REQ-030 Pointers SHALL wrap modulo DEPTH; no gap, duplicate, or reorder across wrap.

Reset
REQ-031 While rst low at an edge: fpc=RESET_PC, resp_pc=RESET_PC, count=0, outstanding=0, drop_cnt=0.
REQ-032 Outputs during/after reset: imem_req_o=0, out_valid_o=0, out_pred_taken_o=0, count_o=0, imem_addr_o=RESET_PC.
REQ-033 Responses arriving after a mid-operation reset SHALL be ignored (outstanding cleared, not dropped-counted).

Configuration
REQ-034 Macro FETCH_JAL_PREDECODE_EN defined: on enqueue of a word with opcode 7'b1101111, SHALL redirect fetch internally to resp_pc + imm_j (sign-extended to XLEN), drop younger outstanding responses as in REQ-026 without flushing queue, and set out_pred_taken_o for that entry; redirect_i takes priority when simultaneous.
REQ-035 Macro undefined: no predecode logic; out_pred_taken_o tied 0; fetch purely sequential between redirects.

Verification
REQ-036 Reset release, zero-wait memory, ready=1 -> out_pc_o 0x0,0x4,0x8,... one per cycle from cycle 3.
REQ-037 DEPTH=4, out_ready_i=0 -> count_o saturates at 4, imem_req_o drops, no responses lost; ready=1 restores order 0x0..0xC.
REQ-038 3 outstanding, gnt delayed, redirect_pc_i=0x100 -> 3 stale responses dropped, next out_pc_o=0x100.
REQ-039 Redirect in same cycle as rvalid and dequeue -> drop_cnt = outstanding-1, out_valid_o=0 that cycle.
REQ-040 FETCH_JAL_PREDECODE_EN, JAL +0x40 at 0x8 -> entries 0x8 (pred_taken=1) then 0x48; word at 0xC never output.
REQ-041 rst low for one cycle with 2 outstanding -> late responses ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue
//   Instruction prefetch queue for a RISC-V front end. Issues word-aligned
//   sequential fetches to an in-order instruction memory and tags each kept
//   response with its PC. Responses are queued for decode. A credit rule
//   (count + outstanding < DEPTH) keeps the queue from overflowing. A redirect
//   from ID flushes the queue, restarts fetch, and drops the responses that
//   are still in flight.
//
//   Optional feature macro: FETCH_JAL_PREDECODE_EN
//     When defined, an enqueued JAL redirects fetch to its target. Younger
//     in-flight responses are dropped, and the entry is flagged in
//     out_pred_taken_o. When undefined, out_pred_taken_o is tied low.
//
// Parameters
//   XLEN      PC/address width (32 or 64)
//   DEPTH     queue entries, power of two, 2..16
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   imem_req_o/addr_o        fetch request and word address
//   imem_gnt_i               request accepted this cycle
//   imem_rvalid_i/rdata_i    in-order response
//   redirect_i/pc_i          flush and restart fetch at redirect_pc_i
//   out_valid_o/ready_i      queue head handshake towards decode
//   out_inst_o/pc_o          head instruction and its PC
//   out_pred_taken_o         head was a predecoded JAL that redirected fetch
//   count_o                  occupied entries
module riscv_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_o,
  output logic [XLEN-1:0]            imem_addr_o,
  input  logic                       imem_gnt_i,
  input  logic                       imem_rvalid_i,
  input  logic [31:0]                imem_rdata_i,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_inst_o,
  output logic [XLEN-1:0]            out_pc_o,
  output logic                       out_pred_taken_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [XLEN-1:0] fpc_q;
  logic [XLEN-1:0] resp_pc_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   drop_cnt_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;

  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic [CW:0]     credit_used;
  logic            fire;
  logic            rsp_take;
  logic            rsp_drop;
  logic            enq;
  logic            deq;
  logic [CW-1:0]   outstanding_nxt;
  logic [XLEN-1:0] redirect_tgt;
  logic            jal_hit;
  logic [XLEN-1:0] jal_tgt;
  logic            unused_bits;

  assign credit_used = {1'b0, count_q} + {1'b0, outstanding_q};

  // Without a grant the credit sum cannot grow, so a raised request stays up
  // until it is granted or a redirect withdraws it.
  assign imem_req_o  = rst && !redirect_i && (credit_used < (CW + 1)'(DEPTH));
  assign imem_addr_o = fpc_q;
  assign fire        = imem_req_o && imem_gnt_i;

  // With nothing outstanding, a response belongs to a request issued before a
  // reset and is ignored.
  assign rsp_take = imem_rvalid_i && (outstanding_q != '0);
  assign rsp_drop = rsp_take && (drop_cnt_q != '0);
  assign enq      = rsp_take && (drop_cnt_q == '0) && !redirect_i;

  assign out_valid_o = (count_q != '0) && !redirect_i;
  assign deq         = out_valid_o && out_ready_i;
  assign out_inst_o  = inst_mem[rd_ptr_q];
  assign out_pc_o    = pc_mem[rd_ptr_q];
  assign count_o     = count_q;

  assign outstanding_nxt = outstanding_q + CW'(fire) - CW'(rsp_take);
  assign redirect_tgt    = {redirect_pc_i[XLEN-1:2], 2'b00};

`ifdef FETCH_JAL_PREDECODE_EN
  logic            pt_mem [DEPTH];
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] jal_sum;

  assign imm_j   = {{(XLEN - 20){imem_rdata_i[31]}}, imem_rdata_i[19:12],
                    imem_rdata_i[20], imem_rdata_i[30:21], 1'b0};
  assign jal_sum = resp_pc_q + imm_j;
  assign jal_tgt = {jal_sum[XLEN-1:2], 2'b00};
  assign jal_hit = enq && (imem_rdata_i[6:0] == 7'b1101111);

  always_ff @(posedge clk) begin
    if (enq) begin
      pt_mem[wr_ptr_q] <= jal_hit;
    end
  end

  assign out_pred_taken_o = out_valid_o && pt_mem[rd_ptr_q];
  assign unused_bits      = ^{redirect_pc_i[1:0], jal_sum[1:0]};
`else
  assign jal_tgt          = '0;
  assign jal_hit          = 1'b0;
  assign out_pred_taken_o = 1'b0;
  assign unused_bits      = ^redirect_pc_i[1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      fpc_q         <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      outstanding_q <= outstanding_nxt;
      if (redirect_i) begin
        // The request is suppressed this cycle, so everything still in flight
        // after this edge is stale.
        fpc_q      <= redirect_tgt;
        resp_pc_q  <= redirect_tgt;
        drop_cnt_q <= outstanding_nxt;
        count_q    <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        if (jal_hit) begin
          // Any grant in this cycle was for a fall-through address, so it is
          // counted among the stale responses.
          fpc_q      <= jal_tgt;
          resp_pc_q  <= jal_tgt;
          drop_cnt_q <= outstanding_nxt;
        end else begin
          if (fire)     fpc_q      <= fpc_q + XLEN'(4);
          if (enq)      resp_pc_q  <= resp_pc_q + XLEN'(4);
          if (rsp_drop) drop_cnt_q <= drop_cnt_q - CW'(1);
        end
        if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(enq) - CW'(deq);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem[wr_ptr_q] <= imem_rdata_i;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue (XLEN=32, DEPTH=4, RESET_PC=0).
// Memory model: gnt follows gnt_en. Granted addresses are queued and returned
// in order while resp_en is high, one cycle after grant at the earliest.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_riscv_fetch_queue;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       imem_req_o;
  logic [XLEN-1:0]            imem_addr_o;
  logic                       imem_gnt_i;
  logic                       imem_rvalid_i;
  logic [31:0]                imem_rdata_i;
  logic                       redirect_i;
  logic [XLEN-1:0]            redirect_pc_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [31:0]                out_inst_o;
  logic [XLEN-1:0]            out_pc_o;
  logic                       out_pred_taken_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;

  riscv_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_inst_o(out_inst_o),
    .out_pc_o(out_pc_o), .out_pred_taken_o(out_pred_taken_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int unsigned     n_vec = 0;
  int unsigned     n_err = 0;
  logic            gnt_en;
  logic            resp_en;
  logic            jal_at_8;
  logic [XLEN-1:0] rq[$];

  function automatic logic [31:0] word_at(input logic [XLEN-1:0] a);
    if (jal_at_8 && a == 32'h8) return 32'h0400006F;  // jal x0, +0x40
    return {a[23:0], 8'h13};
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic settle();
    imem_gnt_i    = gnt_en;
    imem_rvalid_i = resp_en && (rq.size() != 0);
    imem_rdata_i  = (rq.size() != 0) ? word_at(rq[0]) : 32'h0;
    #1;
  endtask

  task automatic tick();
    logic            f;
    logic            r;
    logic [XLEN-1:0] a;
    f = imem_req_o && imem_gnt_i;
    r = imem_rvalid_i;
    a = imem_addr_o;
    @(posedge clk);
    if (r) void'(rq.pop_front());
    if (f) rq.push_back(a);
    @(negedge clk);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      settle();
      tick();
    end
  endtask

  task automatic expect_head(input string tag, input logic [XLEN-1:0] pc, input logic pt);
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd1);
    chk({tag, "_pc"}, 64'(out_pc_o), 64'(pc));
    chk({tag, "_inst"}, 64'(out_inst_o), 64'(word_at(pc)));
    chk({tag, "_pt"}, 64'(out_pred_taken_o), 64'(pt));
  endtask

  task automatic expect_empty(input string tag);
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd0);
  endtask

  initial begin
    rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; out_ready_i = 1'b0;
    gnt_en = 1'b1; resp_en = 1'b1; jal_at_8 = 1'b0;
    cyc(2);

    // Reset state
    settle();
    chk("rst_req", 64'(imem_req_o), 64'd0);
    chk("rst_addr", 64'(imem_addr_o), 64'h0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_pt", 64'(out_pred_taken_o), 64'd0);
    tick();

    // Reset release, zero-wait memory, ready=1: one instruction per cycle
    rst = 1'b1; out_ready_i = 1'b1;
    settle();
    chk("a_req", 64'(imem_req_o), 64'd1);
    chk("a_addr", 64'(imem_addr_o), 64'h0);
    expect_empty("a_c0");
    tick();
    settle(); expect_empty("a_c1"); tick();
    for (int i = 0; i < 5; i++) begin
      settle();
      expect_head("a_seq", 32'(4 * i), 1'b0);
      chk("a_count", 64'(count_o), 64'd1);
      tick();
    end

    // Redirect alongside rvalid and dequeue, then fill to DEPTH with ready=0
    redirect_i = 1'b1; redirect_pc_i = 32'h0;
    settle();
    expect_empty("b_redir");
    chk("b_redir_req", 64'(imem_req_o), 64'd0);
    tick();
    redirect_i = 1'b0; out_ready_i = 1'b0;
    settle();
    chk("b_addr", 64'(imem_addr_o), 64'h0);
    chk("b_count0", 64'(count_o), 64'd0);
    tick();
    cyc(4);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("b_full_count", 64'(count_o), 64'd4);
      chk("b_full_req", 64'(imem_req_o), 64'd0);
      expect_head("b_hold", 32'h0, 1'b0);
      tick();
    end
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      expect_head("b_drain", 32'(4 * i), 1'b0);
      tick();
    end
    gnt_en = 1'b0;
    cyc(8);

    // Three outstanding with delayed responses and gnt, redirect to 0x102
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    cyc(1);
    redirect_i = 1'b0; gnt_en = 1'b1; resp_en = 1'b0;
    cyc(3);
    gnt_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("c_hold_req", 64'(imem_req_o), 64'd1);
      chk("c_hold_addr", 64'(imem_addr_o), 64'h4C);
      tick();
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    settle();
    chk("c_redir_req", 64'(imem_req_o), 64'd0);
    tick();
    redirect_i = 1'b0; gnt_en = 1'b1; resp_en = 1'b1;
    settle();
    chk("c_addr", 64'(imem_addr_o), 64'h100);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle(); expect_empty("c_stale"); tick();
    end
    settle(); expect_head("c_first", 32'h100, 1'b0); tick();

    // Redirect with rvalid in flight and a head waiting: one response dropped
    redirect_i = 1'b1; redirect_pc_i = 32'h300;
    settle(); expect_empty("d_redir"); tick();
    redirect_i = 1'b0;
    settle();
    chk("d_count", 64'(count_o), 64'd0);
    chk("d_addr", 64'(imem_addr_o), 64'h300);
    tick();
    settle(); expect_empty("d_wait"); tick();
    settle(); expect_head("d_first", 32'h300, 1'b0); tick();

    // Back-to-back redirects: the later one wins
    redirect_i = 1'b1; redirect_pc_i = 32'h500;
    settle(); expect_empty("e_redir0"); tick();
    redirect_pc_i = 32'h600;
    settle(); chk("e_count", 64'(count_o), 64'd0); tick();
    redirect_i = 1'b0;
    settle(); chk("e_addr", 64'(imem_addr_o), 64'h600); tick();
    cyc(1);
    settle(); expect_head("e_first", 32'h600, 1'b0); tick();
    settle(); expect_head("e_second", 32'h604, 1'b0); tick();

    // One-cycle reset with two outstanding: late responses ignored
    gnt_en = 1'b0;
    cyc(6);
    redirect_i = 1'b1; redirect_pc_i = 32'h800;
    cyc(1);
    redirect_i = 1'b0; gnt_en = 1'b1; resp_en = 1'b0;
    cyc(2);
    rst = 1'b0; gnt_en = 1'b0; resp_en = 1'b1;
    settle(); chk("f_rst_req", 64'(imem_req_o), 64'd0); tick();
    rst = 1'b1;
    settle();
    chk("f_req", 64'(imem_req_o), 64'd1);
    chk("f_addr", 64'(imem_addr_o), 64'h0);
    chk("f_count", 64'(count_o), 64'd0);
    tick();
    gnt_en = 1'b1;
    settle(); expect_empty("f_late"); chk("f_count2", 64'(count_o), 64'd0); tick();
    settle(); expect_empty("f_wait"); tick();
    settle(); expect_head("f_first", 32'h0, 1'b0); tick();

`ifdef FETCH_JAL_PREDECODE_EN
    // Predecoded JAL at 0x8 with offset +0x40
    gnt_en = 1'b0;
    cyc(6);
    jal_at_8 = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'h0;
    cyc(1);
    redirect_i = 1'b0; gnt_en = 1'b1;
    cyc(2);
    settle(); expect_head("g_0", 32'h0, 1'b0); tick();
    settle(); expect_head("g_4", 32'h4, 1'b0); tick();
    settle(); expect_head("g_jal", 32'h8, 1'b1); tick();
    settle(); expect_empty("g_gap"); tick();
    settle(); expect_head("g_tgt", 32'h48, 1'b0); tick();
    settle(); expect_head("g_tgt4", 32'h4C, 1'b0); tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
